// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 codes, stage state encoding and
// byte-lane helpers used by lsu_mem_ctrl and lsu_load_align.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            2'b00:   rep = {4{wdata[7:0]}};
            2'b01:   rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr_lo and
// sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'(rdata >> {addr_lo, 3'b000});
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data_c = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data_c = {24'b0, byte_lane};
            F3_H:    data_c = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data_c = {16'b0, half_lane};
            default: data_c = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory-access stage: single-outstanding req/gnt/rvalid port,
// byte enables, load alignment and a one-cycle writeback pulse.
// Optional LSU_MISALIGN_TRAP_EN adds misalign_o and traps misaligned half/word accesses.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [2:0]    funct3_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [4:0]    rd_i,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [3:0]    dmem_be_o,
    output logic [AW-1:0] dmem_addr_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [DW-1:0] dmem_rdata_i,
    output logic          wb_valid_o,
    output logic [4:0]    wb_rd_o,
    output logic [DW-1:0] wb_data_o,
    output logic          busy_o
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic          misalign_o
`endif
);

    lsu_state_t  state;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;
    logic        legal_c;
    logic        misaligned_c;
    logic        access_ok_c;
    logic [31:0] align_c;

    assign legal_c = is_legal(req_we_i, funct3_i);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned_c = legal_c && is_misaligned(funct3_i[1:0], addr_i[1:0]);
`else
    assign misaligned_c = 1'b0;
`endif
    assign access_ok_c = legal_c && !misaligned_c;

    lsu_load_align u_align (
        .rdata   (dmem_rdata_i),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data_c  (align_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            req_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_be_o    <= '0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            rd_q         <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        funct3_q    <= funct3_i;
                        addr_lo_q   <= addr_i[1:0];
                        rd_q        <= rd_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (access_ok_c) begin
                            state        <= ST_REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= req_we_i;
                            dmem_be_o    <= be_gen(funct3_i[1:0], addr_i[1:0]);
                            dmem_addr_o  <= {addr_i[AW-1:2], 2'b00};
                            dmem_wdata_o <= wdata_rep(funct3_i[1:0], wdata_i);
                        end else begin
                            // Illegal or trapped access: no memory cycle, only illegal loads write back
                            state      <= ST_DONE;
                            wb_valid_o <= !req_we_i && !legal_c;
                            wb_rd_o    <= rd_i;
                            wb_data_o  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                            misalign_o <= misaligned_c;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_be_o    <= '0;
                        dmem_addr_o  <= '0;
                        dmem_wdata_o <= '0;
                        if (dmem_we_o) begin
                            state       <= ST_IDLE;
                            req_ready_o <= 1'b1;
                            busy_o      <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid_i) begin
                        state      <= ST_DONE;
                        wb_valid_o <= 1'b1;
                        wb_rd_o    <= rd_q;
                        wb_data_o  <= align_c;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    wb_valid_o  <= 1'b0;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_o  <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus random accesses
// checked against an arithmetic model of the load/store rules.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rd = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        mis_out;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_ctrl #(.AW(32), .DW(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .funct3_i      (funct3),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rd_i          (rd),
        .dmem_req_o    (dmem_req),
        .dmem_we_o     (dmem_we),
        .dmem_be_o     (dmem_be),
        .dmem_addr_o   (dmem_addr),
        .dmem_wdata_o  (dmem_wdata),
        .dmem_gnt_i    (dmem_gnt),
        .dmem_rvalid_i (dmem_rvalid),
        .dmem_rdata_i  (dmem_rdata),
        .wb_valid_o    (wb_valid),
        .wb_rd_o       (wb_rd),
        .wb_data_o     (wb_data),
        .busy_o        (busy)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_o    (mis_out)
`endif
    );

`ifndef LSU_MISALIGN_TRAP_EN
    assign mis_out = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: plain arithmetic on the access rules
    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        if (f3[1:0] == 2'd0)      v = 1 << (a % 4);
        else if (f3[1:0] == 2'd1) v = 3 << ((a / 2) % 2 * 2);
        else                      v = 15;
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return (d % 256) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (r >> (8 * (a % 4))) % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (r >> (16 * ((a / 2) % 2))) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r_d,
                              input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
        logic legal;
        logic mis;
        logic [3:0] exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_ld;
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = legal && ((f3[1:0] == 2'd1 && a % 2 != 0) || (f3[1:0] == 2'd2 && a % 4 != 0));
`endif
        exp_be = model_be(f3, a);
        exp_wd = model_wd(f3, wd);
        exp_ld = model_load(f3, a, rdata);

        @(negedge clk);
        vectors++;
        if ({req_ready, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL %s idle_ready: got ready/busy %b required 10", tag, {req_ready, busy});
        end
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd; rd = r_d;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom; rd = 5'($urandom);

        if (!legal || mis) begin
            vectors++;
            if ({dmem_req, busy, wb_valid, mis_out} !== {1'b0, 1'b1, !we && !legal, mis}) begin
                miscompares++;
                $display("FAIL %s nomem_done: got req/busy/wbv/mis %b required %b", tag,
                         {dmem_req, busy, wb_valid, mis_out}, {1'b0, 1'b1, !we && !legal, mis});
            end
            if (!we && !legal) begin
                vectors++;
                if ({wb_rd, wb_data} !== {r_d, 32'h0}) begin
                    miscompares++;
                    $display("FAIL %s illegal_wb: got rd %0d data %h required rd %0d data 0", tag, wb_rd, wb_data, r_d);
                end
            end
            @(negedge clk);
        end else begin
            for (int i = 0; i <= gnt_dly; i++) begin
                vectors++;
                if ({dmem_req, dmem_we, dmem_be, dmem_addr, req_ready, wb_valid} !==
                    {1'b1, we, exp_be, a & 32'hFFFF_FFFC, 1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL %s req_phase: got req %b we %b be %b addr %h rdy %b wbv %b required 1 %b %b %h 0 0",
                             tag, dmem_req, dmem_we, dmem_be, dmem_addr, req_ready, wb_valid, we, exp_be, a & 32'hFFFF_FFFC);
                end
                if (we) begin
                    vectors++;
                    if (dmem_wdata !== exp_wd) begin
                        miscompares++;
                        $display("FAIL %s store_data: got %h required %h", tag, dmem_wdata, exp_wd);
                    end
                end
                dmem_rvalid = 1'($urandom);
                dmem_gnt = (i == gnt_dly);
                @(negedge clk);
            end
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (!we) begin
                for (int j = 0; j <= rv_dly; j++) begin
                    vectors++;
                    if ({dmem_req, wb_valid, busy, req_ready} !== 4'b0010) begin
                        miscompares++;
                        $display("FAIL %s wait_phase: got req/wbv/busy/rdy %b required 0010", tag,
                                 {dmem_req, wb_valid, busy, req_ready});
                    end
                    dmem_rvalid = (j == rv_dly);
                    dmem_rdata  = (j == rv_dly) ? rdata : $urandom;
                    @(negedge clk);
                end
                dmem_rvalid = 1'b0;
                dmem_rdata  = $urandom;
                vectors++;
                if ({wb_valid, wb_rd, wb_data, busy} !== {1'b1, r_d, exp_ld, 1'b1}) begin
                    miscompares++;
                    $display("FAIL %s load_wb: got v %b rd %0d data %h required v 1 rd %0d data %h",
                             tag, wb_valid, wb_rd, wb_data, r_d, exp_ld);
                end
                @(negedge clk);
            end
        end
        vectors++;
        if ({wb_valid, req_ready, busy, dmem_req, mis_out} !== 5'b01000) begin
            miscompares++;
            $display("FAIL %s back_idle: got wbv/rdy/busy/req/mis %b required 01000", tag,
                     {wb_valid, req_ready, busy, dmem_req, mis_out});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({req_ready, busy, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data, mis_out} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got rdy %b busy %b req %b be %b addr %h wbv %b wbd %h required rdy 1, rest 0",
                     req_ready, busy, dmem_req, dmem_be, dmem_addr, wb_valid, wb_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_access("lb_1003",  1'b0, 3'd0, 32'h1003, 32'h0, 5'd1, 32'h80FF_0000, 0, 0);
        run_access("lhu_2002", 1'b0, 3'd5, 32'h2002, 32'h0, 5'd2, 32'hBEEF_1234, 1, 2);
        run_access("lh_2002",  1'b0, 3'd1, 32'h2002, 32'h0, 5'd3, 32'hBEEF_1234, 0, 1);
        run_access("sb_3001",  1'b1, 3'd0, 32'h3001, 32'hA5, 5'd4, 32'h0, 3, 0);
        run_access("sh_3006",  1'b1, 3'd1, 32'h3006, 32'h1234_CAFE, 5'd0, 32'h0, 0, 0);
        run_access("lw_rd0",   1'b0, 3'd2, 32'h3008, 32'h0, 5'd0, 32'hDEAD_BEEF, 0, 0);
        run_access("ill_load", 1'b0, 3'd3, 32'h3010, 32'h0, 5'd9, 32'h0, 0, 0);
        run_access("ill_store",1'b1, 3'd5, 32'h3014, 32'h55, 5'd9, 32'h0, 0, 0);
        run_access("lw_4002",  1'b0, 3'd2, 32'h4002, 32'h0, 5'd5, 32'h0102_0304, 0, 0);
    endtask

    task automatic test_lb_latency();
        // Accept at N; wb_valid must appear exactly at N+3 with fastest memory
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd0; addr = 32'h1003; rd = 5'd6;
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if ({dmem_req, dmem_be, dmem_addr} !== {1'b1, 4'b1000, 32'h1000}) begin
            miscompares++;
            $display("FAIL lat_req: got req %b be %b addr %h required 1 1000 00001000", dmem_req, dmem_be, dmem_addr);
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
        vectors++;
        if (wb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_early: got wb_valid %b at N+2 required 0", wb_valid);
        end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        vectors++;
        if ({wb_valid, wb_data} !== {1'b1, 32'hFFFF_FF80}) begin
            miscompares++;
            $display("FAIL lat_wb: got v %b data %h at N+3 required v 1 data ffffff80", wb_valid, wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2; addr = 32'h6000; rd = 5'd3;
        @(negedge clk);
        addr = 32'h7008; rd = 5'd9;
        vectors++;
        if ({req_ready, dmem_req, dmem_addr} !== {1'b0, 1'b1, 32'h6000}) begin
            miscompares++;
            $display("FAIL b2b_first_req: got rdy %b req %b addr %h required 0 1 00006000", req_ready, dmem_req, dmem_addr);
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        vectors++;
        if ({req_ready, dmem_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_wait: got rdy/req %b required 00", {req_ready, dmem_req});
        end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        vectors++;
        if ({req_ready, wb_valid, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd3, 32'h1111_2222}) begin
            miscompares++;
            $display("FAIL b2b_done: got rdy %b v %b rd %0d data %h required 0 1 3 11112222", req_ready, wb_valid, wb_rd, wb_data);
        end
        @(negedge clk);
        vectors++;
        if ({req_ready, dmem_req, wb_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_idle: got rdy/req/wbv %b required 100", {req_ready, dmem_req, wb_valid});
        end
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if ({dmem_req, dmem_addr} !== {1'b1, 32'h7008}) begin
            miscompares++;
            $display("FAIL b2b_second_req: got req %b addr %h required 1 00007008", dmem_req, dmem_addr);
        end
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h3333_4444;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        vectors++;
        if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd9, 32'h3333_4444}) begin
            miscompares++;
            $display("FAIL b2b_second_wb: got v %b rd %0d data %h required 1 9 33334444", wb_valid, wb_rd, wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2; addr = 32'h5004; rd = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        vectors++;
        if ({req_ready, busy, dmem_req, dmem_be, dmem_addr, wb_valid, wb_rd, wb_data} !==
            {1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 5'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL midrst_state: got rdy %b busy %b req %b addr %h wbv %b wbd %h required 1 0 0 0 0 0",
                     req_ready, busy, dmem_req, dmem_addr, wb_valid, wb_data);
        end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        vectors++;
        if ({wb_valid, req_ready, busy, wb_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL midrst_stale: got wbv %b rdy %b busy %b data %h required 0 1 0 0", wb_valid, req_ready, busy, wb_data);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            run_access("random", 1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom),
                       $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_lb_latency();
        test_directed();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store memory-access stage directly downstream of the load/store address generator.
- Takes a computed effective address, funct3, store data and destination register.
- Drives a single-outstanding request/grant/rvalid data-memory port with byte enables and aligns/sign-extends load data.
- Presents a one-cycle writeback pulse to the register-file writeback path.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed at 32; other values unsupported).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  upstream access valid.
- req_ready_o  out  1  stage can accept; high only in IDLE.
- req_we_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  RV32I width/sign code.
- addr_i  in  AW  effective byte address.
- wdata_i  in  DW  store data (rs2).
- rd_i  in  5  load destination register.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  memory write.
- dmem_be_o  out  4  byte enables.
- dmem_addr_o  out  AW  word-aligned address, bits[1:0] = 0.
- dmem_wdata_o  out  DW  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  DW  read data.
- wb_valid_o  out  1  one-cycle writeback pulse.
- wb_rd_o  out  5  writeback register.
- wb_data_o  out  DW  aligned/extended load data.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE; req_ready_o = 1; all other outputs 0; captured registers cleared. Applies mid-transaction too.
- After reset, dmem_rvalid_i is ignored in IDLE; stale responses are dropped.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on req_valid_i && req_ready_o, capture we/funct3/addr/wdata/rd, then go to REQ. Exception: illegal funct3 goes to DONE (see below).
- REQ: dmem_req_o and the other dmem_* outputs held stable until dmem_gnt_i.
  - Grant on a store: go to IDLE; no writeback.
  - Grant on a load: go to WAIT.
  - dmem_rvalid_i is ignored in REQ.
- WAIT: on dmem_rvalid_i, register aligned data into wb_data_o, then go to DONE.
- DONE: wb_valid_o = 1 for exactly one cycle with wb_rd_o and wb_data_o; next state IDLE.
- rd = 0 loads still access memory and pulse wb_valid_o.
- Minimum load latency: accept at cycle N; dmem_req_o at N+1 (gnt same cycle); rvalid at N+2; wb_valid_o at N+3.
- Store completes at the grant cycle.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Byte enables and store data:
  - Byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111.
  - For loads, dmem_be_o uses the same encoding.
- Load extract: select the byte/half lane from addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Default misalignment handling: half uses addr[1] only, word ignores addr[1:0]; no exception is raised.
- Illegal funct3:
  - Loads 011/110/111 and stores 011–111: no memory access.
  - Illegal load: go to DONE with wb_data_o = 0.
  - Illegal store: dropped; stay IDLE with one busy cycle via DONE, no wb pulse.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined:
  - Extra port misalign_o (out, 1).
  - Access is misaligned when LH/LHU/SH has addr[0] = 1, or LW/SW has addr[1:0] != 0.
  - A misaligned access skips REQ, pulses misalign_o for one cycle in DONE, and produces no wb_valid_o and no dmem_req_o.
  - Reset value of misalign_o is 0.
- When undefined: port absent; default truncation behaviour above.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum.
  - Byte-enable generation function.
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension (rdata, addr[1:0], funct3 in; 32-bit data out).

Test Plan:
- LB at 0x1003, rdata 0x80FF_0000, gnt immediate, rvalid next cycle -> dmem_be_o 4'b1000, dmem_addr_o 0x1000, wb_data_o 0xFFFF_FF80, wb_valid_o at N+3.
- LHU at 0x2002, rdata 0xBEEF_1234 -> wb_data_o 0x0000_BEEF; LH same -> 0xFFFF_BEEF.
- SB at 0x3001, wdata 0x0000_00A5, gnt held low 3 cycles -> dmem_req_o stays high with be 4'b0010 and wdata 0xA5A5_A5A5; no wb_valid_o.
- req_valid_i held high during load -> req_ready_o low from N+1 until IDLE; second request accepted only after DONE.
- rst_i asserted in WAIT, then rvalid arrives -> outputs zero, no wb_valid_o, req_ready_o = 1.
- With LSU_MISALIGN_TRAP_EN: LW at 0x4002 -> no dmem_req_o, misalign_o one-cycle pulse, no wb_valid_o.
